time_unit_counter: RTL

- Generic modulo-N time-unit counter for the clock chain (seconds→minutes→hours); replaces fixed-modulus per-unit counters.
- Counts single-cycle tick enables on one system clock and emits a wrap carry/borrow pulse that drives the next stage's tick.
- Generates a registered 50%-duty square output for hand/indicator drive.
- Supports synchronous preset (time setting), up/down counting and hold.

---
 rtl/time_unit_counter_if.sv | 24 ++
 rtl/time_unit_counter.sv | 61 ++++++
 2 files changed

// File: rtl/time_unit_counter_if.sv
// rtl/time_unit_counter_if.sv - control and status bundle of one time-unit counter stage
interface time_unit_counter_if #(
  parameter int WIDTH = 6
);
  logic             tickIn;
  logic             countDown;
  logic             hold;
  logic             loadEn;
  logic [WIDTH-1:0] loadValue;
  logic [WIDTH-1:0] countOut;
  logic             carryOut;
  logic             borrowOut;
  logic             squareOut;

  modport master (
    output tickIn, countDown, hold, loadEn, loadValue,
    input  countOut, carryOut, borrowOut, squareOut
  );

  modport slave (
    input  tickIn, countDown, hold, loadEn, loadValue,
    output countOut, carryOut, borrowOut, squareOut
  );
endinterface

// File: rtl/time_unit_counter.sv
// rtl/time_unit_counter.sv - modulo-N up/down time-unit counter with wrap pulses and square output
module time_unit_counter #(
  parameter int MODULUS     = 60,
  parameter int WIDTH       = 6,
  parameter int RESET_VALUE = 0
) (
  input  logic                  clock,
  input  logic                  resetN,
  time_unit_counter_if.slave    bus
);
  // One extra bit so MODULUS == 2^WIDTH is still representable for the load compare.
  localparam logic [WIDTH:0]   MOD_WIDE     = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_COUNT    = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] HALF_COUNT   = WIDTH'(MODULUS / 2);
  localparam logic [WIDTH-1:0] RESET_COUNT  = WIDTH'(RESET_VALUE);
  localparam logic             RESET_SQUARE = (RESET_VALUE >= MODULUS / 2);

  logic [WIDTH-1:0] nextCount;
  logic             nextCarry;
  logic             nextBorrow;

  always_comb begin
    nextCount  = bus.countOut;
    nextCarry  = 1'b0;
    nextBorrow = 1'b0;
    if (bus.loadEn) begin
      nextCount = ({1'b0, bus.loadValue} < MOD_WIDE) ? bus.loadValue : MAX_COUNT;
    end else if (!bus.hold && bus.tickIn) begin
      if (bus.countDown) begin
        if (bus.countOut == '0) begin
          nextCount  = MAX_COUNT;
          nextBorrow = 1'b1;
        end else begin
          nextCount = bus.countOut - 1'b1;
        end
      end else begin
        // Explicit wrap rather than natural rollover, so a full-width modulus behaves too.
        if (bus.countOut == MAX_COUNT) begin
          nextCount = '0;
          nextCarry = 1'b1;
        end else begin
          nextCount = bus.countOut + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      bus.countOut  <= RESET_COUNT;
      bus.carryOut  <= 1'b0;
      bus.borrowOut <= 1'b0;
      bus.squareOut <= RESET_SQUARE;
    end else begin
      bus.countOut  <= nextCount;
      bus.carryOut  <= nextCarry;
      bus.borrowOut <= nextBorrow;
      bus.squareOut <= (nextCount >= HALF_COUNT);
    end
  end
endmodule
